// File: rtl/vec_beat_sequencer.sv
// rtl/vec_beat_sequencer.sv - splits an accepted vector instruction into DATA_WIDTH beat descriptors
// Snapshots avl<<sew at accept, then walks the byte count one beat per handshake.
module vec_beat_sequencer #(
   parameter int VLEN        = 16384,
   parameter int DATA_WIDTH  = 64,
   parameter int VLMAX       = VLEN >> 3,
   parameter int VLEN_B_BITS = $clog2(VLMAX),
   parameter int BEAT_BITS   = $clog2(VLMAX / (DATA_WIDTH / 8)) + 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [VLEN_B_BITS-1:0]    avl,
   input  logic [1:0]                sew,
   input  logic                      vill,
   input  logic                      new_vl,
   input  logic                      issue_valid,
   output logic                      issue_ready,
   output logic                      beat_valid,
   input  logic                      beat_ready,
   output logic [BEAT_BITS-1:0]      beat_idx,
   output logic [DATA_WIDTH/8-1:0]   beat_mask,
   output logic                      beat_last,
   output logic                      done,
   output logic                      cfg_stale
);

   localparam int BEAT_BYTES = DATA_WIDTH / 8;
   localparam int CNT_W      = VLEN_B_BITS + 3;
   localparam logic [CNT_W-1:0] BEAT_BYTES_C = CNT_W'(BEAT_BYTES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     remaining_q, remaining_d;
   logic [CNT_W-1:0]     total_bytes;
   logic [BEAT_BITS-1:0] idx_q, idx_d;
   logic                 stale_q, stale_d;
   logic                 accept;
   logic                 handshake;
   logic                 last_beat;

   // Widened before the shift so avl<<3 never loses its top bits.
   assign total_bytes = {3'b000, avl} << sew;

   assign issue_ready = (state_q == IDLE) && !rst;
   assign accept      = issue_valid && issue_ready;
   assign beat_valid  = (state_q == RUN);
   assign handshake   = beat_valid && beat_ready;
   assign last_beat   = (remaining_q <= BEAT_BYTES_C);
   assign beat_last   = beat_valid && last_beat;
   assign beat_idx    = idx_q;
   assign done        = (state_q == DONE);
   assign cfg_stale   = stale_q;

   always_comb begin
      beat_mask = '0;
      if (beat_valid) begin
         for (int i = 0; i < BEAT_BYTES; i++) begin
            beat_mask[i] = (remaining_q > CNT_W'(i));
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      idx_d       = idx_q;
      stale_d     = stale_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               stale_d     = 1'b0;
               idx_d       = '0;
               remaining_d = total_bytes;
               state_d     = (vill || total_bytes == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (new_vl) stale_d = 1'b1;
            if (handshake) begin
               if (last_beat) begin
                  state_d     = DONE;
                  idx_d       = '0;
                  remaining_d = '0;
               end else begin
                  idx_d       = idx_q + 1'b1;
                  remaining_d = remaining_q - BEAT_BYTES_C;
               end
            end
         end
         DONE: begin
            if (new_vl) stale_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         idx_q       <= '0;
         stale_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         idx_q       <= idx_d;
         stale_q     <= stale_d;
      end
   end

endmodule

// File: tb/tb_vec_beat_sequencer.sv
// tb/tb_vec_beat_sequencer.sv - scoreboard bench for vec_beat_sequencer
// Driver pushes expected beats per instruction; a negedge monitor pops and compares.
module tb_vec_beat_sequencer;

   localparam int VLEN        = 16384;
   localparam int DATA_WIDTH  = 64;
   localparam int VLMAX       = VLEN >> 3;
   localparam int VLEN_B_BITS = $clog2(VLMAX);
   localparam int BEAT_BYTES  = DATA_WIDTH / 8;
   localparam int BEAT_BITS   = $clog2(VLMAX / BEAT_BYTES) + 1;

   logic                    clk;
   logic                    rst;
   logic [VLEN_B_BITS-1:0]  avl;
   logic [1:0]              sew;
   logic                    vill;
   logic                    new_vl;
   logic                    issue_valid;
   logic                    issue_ready;
   logic                    beat_valid;
   logic                    beat_ready;
   logic [BEAT_BITS-1:0]    beat_idx;
   logic [BEAT_BYTES-1:0]   beat_mask;
   logic                    beat_last;
   logic                    done;
   logic                    cfg_stale;

   vec_beat_sequencer #(
      .VLEN       (VLEN),
      .DATA_WIDTH (DATA_WIDTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .avl         (avl),
      .sew         (sew),
      .vill        (vill),
      .new_vl      (new_vl),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .beat_valid  (beat_valid),
      .beat_ready  (beat_ready),
      .beat_idx    (beat_idx),
      .beat_mask   (beat_mask),
      .beat_last   (beat_last),
      .done        (done),
      .cfg_stale   (cfg_stale)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int idx;
      int mask;
      int last;
   } beat_t;

   beat_t beat_q[$];
   int    ins_q[$];
   int    chk_cnt   = 0;
   int    pass_cnt  = 0;
   int    ready_pct = 100;
   bit    junk      = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      chk_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference: beats are ceil(bytes/8) slices of the byte range avl*2^sew.
   task automatic push_model(input int a, input int s, input bit v);
      int    total;
      int    nb;
      int    rem;
      beat_t bt;
      total = a * (1 << s);
      nb    = (v || total == 0) ? 0 : (total + BEAT_BYTES - 1) / BEAT_BYTES;
      for (int b = 0; b < nb; b++) begin
         rem     = total - b * BEAT_BYTES;
         bt.idx  = b % (1 << BEAT_BITS);
         bt.mask = (rem >= BEAT_BYTES) ? (1 << BEAT_BYTES) - 1 : (1 << rem) - 1;
         bt.last = (rem <= BEAT_BYTES) ? 1 : 0;
         beat_q.push_back(bt);
      end
      ins_q.push_back(nb);
   endtask

   task automatic junk_step();
      if (junk) begin
         new_vl = ($urandom_range(7) == 0);
         avl    = VLEN_B_BITS'($urandom);
         sew    = 2'($urandom);
         vill   = 1'($urandom);
      end else begin
         new_vl = 1'b0;
      end
   endtask

   task automatic issue(input int a, input int s, input bit v);
      int n;
      n = 0;
      do begin
         @(posedge clk); #1;
         junk_step();
         n++;
      end while (!issue_ready && n < 5000);
      if (!issue_ready) begin
         check("issue_ready_timeout", 0, 1);
         return;
      end
      avl         = VLEN_B_BITS'(a);
      sew         = 2'(s);
      vill        = v;
      issue_valid = 1'b1;
      push_model(a, s, v);
      @(posedge clk); #1;
      issue_valid = 1'b0;
      junk_step();
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(posedge clk); #1;
         junk_step();
         n++;
      end while (!(issue_ready && beat_q.size() == 0) && n < 20000);
      if (!(issue_ready && beat_q.size() == 0)) check("idle_timeout", 0, 1);
   endtask

   initial begin
      beat_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         beat_ready = ($urandom_range(99) < ready_pct);
      end
   end

   // Monitor: tracks busy / done / stale from observed handshakes only.
   bit m_busy  = 1'b0;
   bit m_stale = 1'b0;
   bit m_due   = 1'b0;
   bit m_acc;
   bit m_due_next;
   int m_nb;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            beat_q.delete();
            ins_q.delete();
            m_busy  = 1'b0;
            m_stale = 1'b0;
            m_due   = 1'b0;
         end else begin
            m_acc      = issue_valid && issue_ready;
            m_due_next = 1'b0;
            check("issue_ready", int'(issue_ready), int'(!m_busy));
            check("cfg_stale", int'(cfg_stale), int'(m_stale));
            if (done || m_due) check("done", int'(done), int'(m_due));
            check("beat_valid", int'(beat_valid), int'(m_busy && beat_q.size() > 0));
            if (beat_valid && beat_q.size() > 0) begin
               check("beat_idx", int'(beat_idx), beat_q[0].idx);
               check("beat_mask", int'(beat_mask), beat_q[0].mask);
               check("beat_last", int'(beat_last), beat_q[0].last);
               if (beat_ready) begin
                  if (beat_q[0].last != 0) m_due_next = 1'b1;
                  void'(beat_q.pop_front());
               end
            end
            if (m_acc) begin
               if (ins_q.size() > 0) begin
                  m_nb = ins_q.pop_front();
                  if (m_nb == 0) m_due_next = 1'b1;
               end else begin
                  check("accept_without_issue", 1, 0);
               end
            end
            if (m_acc) m_stale = 1'b0;
            else if (new_vl && m_busy) m_stale = 1'b1;
            if (m_due) m_busy = 1'b0;
            if (m_acc) m_busy = 1'b1;
            m_due = m_due_next;
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b1;
      avl         = '0;
      sew         = '0;
      vill        = 1'b0;
      new_vl      = 1'b0;
      issue_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_beat_valid", int'(beat_valid), 0);
      check("rst_beat_idx", int'(beat_idx), 0);
      check("rst_beat_mask", int'(beat_mask), 0);
      check("rst_beat_last", int'(beat_last), 0);
      check("rst_done", int'(done), 0);
      check("rst_cfg_stale", int'(cfg_stale), 0);
      check("rst_issue_ready", int'(issue_ready), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_issue_ready", int'(issue_ready), 1);

      ready_pct = 100;
      issue(10, 0, 1'b0);
      issue(4, 3, 1'b0);
      wait_idle();

      ready_pct = 0;
      issue(3, 1, 1'b0);
      repeat (3) @(posedge clk);
      #1 ready_pct = 100;
      wait_idle();

      issue(8, 0, 1'b1);
      issue(0, 2, 1'b0);
      wait_idle();

      ready_pct = 50;
      issue(16, 2, 1'b0);
      @(posedge clk); #1;
      avl    = VLEN_B_BITS'(1);
      new_vl = 1'b1;
      @(posedge clk); #1;
      new_vl = 1'b0;
      wait_idle();
      check("stale_set", int'(cfg_stale), 1);
      issue(2, 0, 1'b0);
      check("stale_clear", int'(cfg_stale), 0);
      wait_idle();

      ready_pct = 100;
      issue(8, 3, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_beat_valid", int'(beat_valid), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_issue_ready", int'(issue_ready), 1);
      check("midrst_beat_idx", int'(beat_idx), 0);
      issue(5, 0, 1'b0);
      wait_idle();

      issue(VLMAX >> 3, 3, 1'b0);
      issue(VLMAX - 1, 0, 1'b0);
      issue(VLMAX - 1, 3, 1'b0);
      wait_idle();

      junk = 1'b1;
      repeat (150) begin
         ready_pct = $urandom_range(30, 100);
         issue($urandom_range(48), $urandom_range(3), ($urandom_range(11) == 0));
      end
      wait_idle();
      junk = 1'b0;
      repeat (2) @(posedge clk);
      check("beat_q_drained", beat_q.size(), 0);
      check("ins_q_drained", ins_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
